// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg : shared pipeline codes and fetch-target helpers
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_stage_pkg;

  localparam logic [1:0]  PC_SEQ    = 2'd0;
  localparam logic [1:0]  PC_JUMP   = 2'd1;
  localparam logic [1:0]  PC_JR     = 2'd2;
  localparam logic [1:0]  PC_BRANCH = 2'd3;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] jump_target(input logic [3:0]  region,
                                              input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] imm);
    return pc4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}}))
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage : PC register, next-PC selection and IF/ID pipeline register
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               regIF_en,
  input  logic               regID_en,
  input  logic               nopMux,
  input  logic [1:0]         pcmux,
  input  logic [31:0]        rs_value,
  input  logic [31:0]        imem_data,
  output logic [31:0]        imem_addr,
  output logic [31:0]        instruction_ID,
  output logic [31:0]        pc_plus4_ID,
  output logic               valid_ID,
  output logic [1:0]         fetch_state,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_id_q, pc4_id_d;
  logic         valid_q, valid_d;
  fetch_state_t state_q;

  logic [31:0]  pc_plus4;
  logic [31:0]  target;
  logic         redirect;

  assign pc_plus4 = pc_q + 32'd4;

  // A frozen or bubbled ID slot must never steer the PC.
  assign redirect = (pcmux != PC_SEQ) && regID_en && valid_q;

  always_comb begin
    target = branch_target(pc4_id_q, instr_q[15:0]);
    case (pcmux)
      PC_JUMP: target = jump_target(pc4_id_q[31:28], instr_q[25:0]);
      PC_JR:   target = rs_value;
      default: target = branch_target(pc4_id_q, instr_q[15:0]);
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc4_id_d = pc4_id_q;
    valid_d  = valid_q;
    if (redirect) begin
      // No delay slot: the wrong-path word fetched this cycle is dropped.
      pc_d    = target;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else begin
      if (regIF_en)
        pc_d = pc_plus4;
      if (regID_en) begin
        if (nopMux) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else begin
          instr_d  = imem_data;
          pc4_id_d = pc_plus4;
          valid_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc4_id_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc4_id_q <= pc4_id_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= ST_RUN;
    else if (redirect)
      state_q <= ST_FLUSH;
    else if (!regIF_en)
      state_q <= ST_STALL;
    else
      state_q <= ST_RUN;
  end

  sat_counter #(.W(COUNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!regIF_en && !redirect),
    .count (stall_count)
  );

  sat_counter #(.W(COUNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (redirect),
    .count (flush_count)
  );

  assign imem_addr      = pc_q;
  assign instruction_ID = instr_q;
  assign pc_plus4_ID    = pc4_id_q;
  assign valid_ID       = valid_q;
  assign fetch_state    = state_q;

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS pipeline. It holds the PC, drives the instruction-memory address and computes the next PC from the ID-stage redirect select. It obeys the stall and bubble controls of the hazard unit and delivers `instruction_ID` to the decode and hazard logic. It also keeps saturating stall and flush counters for performance debug.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `COUNT_W`, default 16: width of each performance counter.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `regIF_en`  in  1  1 = PC may advance; 0 = PC holds.
- `regID_en`  in  1  1 = IF/ID register may load; 0 = IF/ID holds.
- `nopMux`  in  1  1 = IF/ID loads a bubble instead of the fetched word.
- `pcmux`  in  2  next-PC select from decode of `instruction_ID`: 0 seq, 1 jump, 2 jr, 3 branch-taken.
- `rs_value`  in  32  register-file read of rs; the jr target.
- `imem_data`  in  32  combinational instruction-memory read data for `imem_addr`.
- `imem_addr`  out  32  current PC.
- `instruction_ID`  out  32  IF/ID instruction.
- `pc_plus4_ID`  out  32  PC+4 of the instruction in IF/ID.
- `valid_ID`  out  1  1 = `instruction_ID` is a real instruction; 0 = bubble.
- `fetch_state`  out  2  FSM state: RUN=0, STALL=1, FLUSH=2.
- `stall_count`  out  COUNT_W  cycles with `regIF_en`=0.
- `flush_count`  out  COUNT_W  redirects taken.

## Operation
- Reset values:
  - PC = `RESET_PC`
  - `instruction_ID` = 32'h0, `pc_plus4_ID` = 0, `valid_ID` = 0
  - `fetch_state` = RUN
  - both counters = 0
- Targets, computed from IF/ID contents (32-bit modulo arithmetic):
  - jump = {`pc_plus4_ID`[31:28], `instruction_ID`[25:0], 2'b00}
  - jr = `rs_value`
  - branch = `pc_plus4_ID` + (sign-extended `instruction_ID`[15:0] << 2)
- Redirect: `pcmux` != 0 and `regID_en` = 1 and `valid_ID` = 1.
  - Redirect is ignored when `regID_en` = 0, because the ID instruction is frozen and will re-present.
  - Redirect is ignored when `valid_ID` = 0; a bubble never redirects.
- Per-edge priority:
  1. Redirect. PC <= target regardless of `regIF_en`. IF/ID <= bubble. `flush_count` += 1. There is no delay slot: the wrong-path word fetched this cycle is discarded.
  2. Otherwise, if `regIF_en` = 1: PC <= PC + 4. Wraps 32'hFFFF_FFFC -> 0.
  3. IF/ID, no redirect: if `regID_en` = 0, hold. Else if `nopMux` = 1, load bubble. Else load {`imem_data`, PC+4, valid 1}.
  4. Bubble = {32'h0, `pc_plus4_ID` unchanged, valid 0}.
- `stall_count` += 1 on each edge where `regIF_en` = 0 and no redirect occurs.
- Both counters saturate at all-ones and never wrap.
- FSM next state, evaluated each edge:
  - redirect -> FLUSH
  - else `regIF_en` = 0 -> STALL
  - else -> RUN
  - FLUSH lasts exactly one cycle unless another redirect or stall follows.
- Combination `regIF_en` = 1, `regID_en` = 0 is legal: the PC advances and the fetched word is lost. The hazard unit never issues this; the stage does not guard against it.

## Timing
- `imem_addr` changes only after a clock edge or an asynchronous reset.
- Fetch-to-ID latency: 1 cycle. A word read at PC in cycle n appears on `instruction_ID` in cycle n+1.
- Redirect penalty: exactly 1 bubble cycle. The target instruction is on `instruction_ID` two edges after the redirect cycle.
- Stall: PC and IF/ID hold for as many cycles as the enables stay 0. The first edge with enables at 1 resumes without loss.
- Reset asserted mid-stall or mid-redirect:
  - all outputs take their reset values asynchronously
  - the first edge after deassertion fetches `RESET_PC`
  - no pending redirect survives reset

## Structure
- Shared pipeline package holds:
  - `pcmux` codes PC_SEQ=0, PC_JUMP=1, PC_JR=2, PC_BRANCH=3
  - NOP_INSTR = 32'h0
  - `fetch_state` encoding RUN, STALL, FLUSH
- One sub-module, `sat_counter` (parameter W; inputs `clk`, `reset`, `inc`; output `count`), instantiated twice.
- Target computation and the PC/IF/ID registers stay in `fetch_stage`.

## Test plan
- Reset with `RESET_PC`=0, enables 1, memory returns 32'h2008_0005 at address 0:
  - after the 1st edge, `instruction_ID` = 32'h2008_0005, `pc_plus4_ID` = 4, `valid_ID` = 1, `imem_addr` = 4.
- Hold `regIF_en` = `regID_en` = 0 for 3 cycles at PC 8, then release:
  - PC stays 8, IF/ID is frozen, `stall_count` = 3, `fetch_state` = STALL.
  - after release, sequential fetch resumes at 8.
- `nopMux` = 1, `regID_en` = 1, `regIF_en` = 0 for 1 cycle:
  - `valid_ID` = 0, `instruction_ID` = 0, PC unchanged.
- BEQ 32'h1000_0003 in ID with `pc_plus4_ID` = 32'h10 and `pcmux` = 3:
  - next `imem_addr` = 32'h1C, one bubble, `flush_count` = 1, `fetch_state` = FLUSH.
- JAL target field 26'h40 with `pc_plus4_ID` = 32'h2000_0004 and `pcmux` = 1:
  - next PC = 32'h2000_0100.
- jr (`pcmux` = 2) with `rs_value` = 32'h44, issued while `regID_en` = 0:
  - no redirect while held; redirect to 32'h44 on the first edge with `regID_en` = 1.
  - assert reset mid-sequence: all outputs clear immediately and `flush_count` returns to 0.
